mem_copy_dma: RTL and testbench

Bus initiator for the 16-bit synchronous memory bus (ce/we/addr/wdata/rdata, 1-cycle registered read latency). It copies a block of i_len words from i_src to i_dst, one word at a time: read, capture, write. It sits beside the CPU as a second master behind a bus arbiter, which supplies i_grant. It is used for program/data block moves between RAM regions.

---
 rtl/mem_bus_pkg.sv | 22 ++
 rtl/mem_copy_dma.sv | 105 ++++++++++
 tb/tb_mem_copy_dma.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the 16-bit synchronous memory bus.
// Used by the CPU, the bus arbiter and the block-copy DMA.
package mem_bus_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  typedef struct packed {
    logic              ce;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_t;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    CAP,
    WR
  } dma_state_t;

endpackage

// File: rtl/mem_copy_dma.sv
// Block-copy bus initiator: read, capture, write one word at a time.
// Second bus master behind the arbiter; waits on i_grant.
module mem_copy_dma #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_src,
  input  logic [ADDR_W-1:0] i_dst,
  input  logic [LEN_W-1:0]  i_len,
  input  logic              i_grant,
  output logic              o_ce,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_w_data,
  input  logic [DATA_W-1:0] i_r_data,
  output logic              o_busy,
  output logic              o_done,
  output logic [LEN_W-1:0]  o_count
);

  import mem_bus_pkg::*;

  dma_state_t        state;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  cnt_nxt;
  logic [ADDR_W-1:0] src_nxt;

  assign cnt_nxt = o_count + LEN_W'(1);
  assign src_nxt = src + ADDR_W'(1);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      src      <= '0;
      dst      <= '0;
      len      <= '0;
      o_ce     <= 1'b0;
      o_we     <= 1'b0;
      o_addr   <= '0;
      o_w_data <= '0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_count  <= '0;
    end else begin
      o_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_start && i_len != '0) begin
            src     <= i_src;
            dst     <= i_dst;
            len     <= i_len;
            o_count <= '0;
            o_ce    <= 1'b1;
            o_we    <= 1'b0;
            o_addr  <= i_src;
            o_busy  <= 1'b1;
            state   <= RD;
          end else if (i_start) begin
            o_done <= 1'b1;
          end
        end
        RD: begin
          if (i_grant) begin
            o_ce  <= 1'b0;
            state <= CAP;
          end
        end
        CAP: begin
          // read data arrives one cycle after the granted read edge
          o_w_data <= i_r_data;
          o_ce     <= 1'b1;
          o_we     <= 1'b1;
          o_addr   <= dst;
          state    <= WR;
        end
        WR: begin
          if (i_grant) begin
            src     <= src_nxt;
            dst     <= dst + ADDR_W'(1);
            o_count <= cnt_nxt;
            if (cnt_nxt == len) begin
              o_ce   <= 1'b0;
              o_we   <= 1'b0;
              o_busy <= 1'b0;
              o_done <= 1'b1;
              state  <= IDLE;
            end else begin
              o_we   <= 1'b0;
              o_addr <= src_nxt;
              state  <= RD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_dma.sv
// Randomized self-checking bench for mem_copy_dma against a
// word-level copy model and a sparse RAM with 1-cycle read latency.
module tb_mem_copy_dma;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] src = '0;
  logic [15:0] dst = '0;
  logic [15:0] len = '0;
  logic        grant = 1'b1;
  logic        ce;
  logic        we;
  logic [15:0] addr;
  logic [15:0] w_data;
  logic [15:0] r_data = '0;
  logic        busy;
  logic        done;
  logic [15:0] count;

  logic        ld = 1'b0;
  logic [15:0] ld_addr = '0;
  logic [15:0] ld_data = '0;

  logic [15:0] mem [0:65535];
  bit          mem_ok [0:65535];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_copy_dma dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_src   (src),
    .i_dst   (dst),
    .i_len   (len),
    .i_grant (grant),
    .o_ce    (ce),
    .o_we    (we),
    .o_addr  (addr),
    .o_w_data(w_data),
    .i_r_data(r_data),
    .o_busy  (busy),
    .o_done  (done),
    .o_count (count)
  );

  function automatic logic [15:0] bg(input logic [15:0] a);
    return (a * 16'h9e37) ^ 16'h5a5a;
  endfunction

  function automatic logic [15:0] rd_word(input logic [15:0] a);
    return mem_ok[a] ? mem[a] : bg(a);
  endfunction

  // bus slave: ops complete only on granted edges
  always @(posedge clk) begin
    if (ld) begin
      mem[ld_addr]    <= ld_data;
      mem_ok[ld_addr] <= 1'b1;
    end else if (ce && grant) begin
      if (we) begin
        mem[addr]    <= w_data;
        mem_ok[addr] <= 1'b1;
      end else begin
        r_data <= rd_word(addr);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [15:0] a, input logic [15:0] v);
    @(negedge clk);
    ld = 1'b1; ld_addr = a; ld_data = v;
    @(negedge clk);
    ld = 1'b0;
  endtask

  // expected window: d-2 .. d+n+1, first k words copied from s
  logic [15:0] win_a [$];
  logic [15:0] win_v [$];

  task automatic plan(input logic [15:0] s, input logic [15:0] d,
                      input int n, input int k);
    win_a.delete();
    win_v.delete();
    for (int i = -2; i < n + 2; i++) begin
      logic [15:0] a;
      a = d + 16'(i);
      win_a.push_back(a);
      if (i >= 0 && i < k) win_v.push_back(rd_word(s + 16'(i)));
      else win_v.push_back(rd_word(a));
    end
  endtask

  task automatic verify(input string tag);
    for (int i = 0; i < win_a.size(); i++)
      check(tag, {win_a[i], rd_word(win_a[i])}, {win_a[i], win_v[i]});
  endtask

  // mode 0: grant always, 1: random grant, 2: scripted stalls
  task automatic run_copy(input logic [15:0] s, input logic [15:0] d,
                          input logic [15:0] n, input int mode,
                          input bit inject, output int busy_cyc,
                          output int done_cnt, output int stalls,
                          output bit ce_seen);
    int cyc, s_rd, s_wr;
    bit fin, prev_stall;
    logic [17:0] prev;
    busy_cyc = 0; done_cnt = 0; stalls = 0; ce_seen = 0;
    cyc = 0; s_rd = 0; s_wr = 0; fin = 0; prev_stall = 0; prev = '0;
    @(negedge clk);
    start = 1'b1; src = s; dst = d; len = n;
    @(negedge clk);
    start = 1'b0;
    while (!fin && cyc < 1000) begin
      if (prev_stall) check("stall_hold", {14'd0, ce, we, addr}, {14'd0, prev});
      if (ce) ce_seen = 1;
      if (busy) busy_cyc++;
      if (done) begin
        done_cnt++;
        fin = 1;
      end
      if (inject && cyc == 4) begin
        start = 1'b1; src = ~s; dst = ~d; len = n + 16'd3;
      end else begin
        start = 1'b0; src = s; dst = d; len = n;
      end
      grant = 1'b1;
      if (mode == 1) begin
        grant = ($urandom_range(0, 3) != 0);
      end else if (mode == 2) begin
        if (ce && !we && count == 16'd0 && s_rd < 5) begin
          grant = 1'b0; s_rd++;
        end else if (ce && we && count == 16'd1 && s_wr < 3) begin
          grant = 1'b0; s_wr++;
        end
      end
      prev_stall = ce && !grant;
      prev = {ce, we, addr};
      if (prev_stall) stalls++;
      cyc++;
      if (!fin) @(negedge clk);
    end
    if (!fin) check("done_timeout", 0, 1);
    grant = 1'b1;
    @(negedge clk);
    check("done_width", {31'd0, done}, 0);
    check("idle_busy", {30'd0, busy, ce}, 0);
  endtask

  task automatic full_copy(input string tag, input logic [15:0] s,
                           input logic [15:0] d, input logic [15:0] n,
                           input int mode, input bit inject,
                           input int busy_want);
    int b, dc, st;
    bit cs;
    plan(s, d, int'(n), int'(n));
    run_copy(s, d, n, mode, inject, b, dc, st, cs);
    check({tag, "_busy"}, b, busy_want < 0 ? 3 * int'(n) + st : busy_want);
    check({tag, "_done"}, dc, 1);
    check({tag, "_count"}, {16'd0, count}, {16'd0, n});
    verify({tag, "_mem"});
  endtask

  initial begin
    int b, dc, st;
    bit cs;
    logic [15:0] s, d, n;

    repeat (3) @(negedge clk);
    check("rst_out", {ce, we, busy, done, addr, w_data, count}, 0);
    rst_n = 1'b1;

    // basic copy
    for (int i = 0; i < 4; i++) load(16'h0010 + 16'(i), 16'(i + 1));
    full_copy("basic", 16'h0010, 16'h0040, 16'd4, 0, 0, 12);
    for (int i = 0; i < 4; i++)
      check("basic_val", {16'd0, rd_word(16'h0040 + 16'(i))}, i + 1);

    // zero length
    run_copy(16'h0020, 16'h0050, 16'd0, 0, 0, b, dc, st, cs);
    check("zero_done", dc, 1);
    check("zero_busy", b, 0);
    check("zero_ce", {31'd0, cs}, 0);

    // scripted stalls
    full_copy("stall", 16'h0200, 16'h0300, 16'd3, 2, 0, 17);

    // address wrap
    load(16'hffff, 16'haaaa);
    load(16'h0000, 16'h5555);
    full_copy("wrap", 16'hffff, 16'h0100, 16'd2, 0, 0, 6);
    check("wrap_0", {16'd0, rd_word(16'h0100)}, 32'haaaa);
    check("wrap_1", {16'd0, rd_word(16'h0101)}, 32'h5555);

    // reset after the 2nd write
    plan(16'h0400, 16'h0500, 8, 2);
    @(negedge clk);
    start = 1'b1; src = 16'h0400; dst = 16'h0500; len = 16'd8;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100 && count != 16'd2; i++) @(negedge clk);
    check("rst_at2", {16'd0, count}, 2);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid", {ce, we, busy, done, addr, w_data, count}, 0);
    @(negedge clk);
    check("rst_nodone", {31'd0, done}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_nodone2", {31'd0, done}, 0);
    verify("rst_mem");
    full_copy("after_rst", 16'h0600, 16'h0700, 16'd3, 0, 0, 9);

    // start while busy
    full_copy("inject", 16'h0800, 16'h0900, 16'd4, 0, 1, 12);

    // randomized copies, disjoint regions
    for (int t = 0; t < 25; t++) begin
      s = 16'h1000 + 16'($urandom_range(0, 16'h0fff));
      d = 16'h8000 + 16'($urandom_range(0, 16'h0fff));
      n = 16'($urandom_range(1, 7));
      full_copy("rand", s, d, n, 1, ($urandom_range(0, 3) == 0), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
